// File: rtl/mempool_ipu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mempool_ipu_arbiter_pkg
//
// Shared definitions for the tile-level IPU sharing logic.
//   IpuShareFactor      : number of cores sharing one IPU instance
//   DefaultIdWidth      : width of a core's accelerator id
//   IpuIdWidthDefault   : widened id seen by the shared IPU (tag + core id)
//   acc_ipu_req_t       : offload request carrying the widened id
//   acc_ipu_resp_t      : offload response carrying the widened id
//   idx_width()         : requester-tag width for a given requester count
// ---------------------------------------------------------------------------
package mempool_ipu_arbiter_pkg;

    localparam int unsigned IpuShareFactor = 4;
    localparam int unsigned DefaultIdWidth = 5;

    // A single requester still carries one (constant-zero) tag bit so the
    // IPU id layout does not change shape with the share factor.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IpuIdWidthDefault = DefaultIdWidth + idx_width(IpuShareFactor);

    typedef struct packed {
        logic [31:0]                  addr;
        logic [IpuIdWidthDefault-1:0] id;
        logic [31:0]                  data_op;
        logic [31:0]                  data_arga;
        logic [31:0]                  data_argb;
        logic [31:0]                  data_argc;
    } acc_ipu_req_t;

    typedef struct packed {
        logic [IpuIdWidthDefault-1:0] id;
        logic [31:0]                  data;
        logic                         error;
    } acc_ipu_resp_t;

endpackage

// File: rtl/mempool_ipu_arbiter_rr_lock.sv
// ---------------------------------------------------------------------------
// mempool_ipu_arbiter_rr_lock
//
// Round-robin arbiter with a grant lock. Once a grant is presented and not
// accepted, it is frozen until the handshake so the downstream sees stable
// valid and data.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-input request (already qualified by the caller)
//   ready_i       : downstream ready
//   valid_o       : downstream valid (any request, or a held lock)
//   gnt_o         : one-hot grant, zero when valid_o is low
//   idx_o         : binary grant index, 0 when nothing is granted
// ---------------------------------------------------------------------------
module mempool_ipu_arbiter_rr_lock #(
    parameter  int unsigned NumIn    = 4,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumIn-1:0]    req_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [NumIn-1:0]    gnt_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [IdxWidth-1:0] rr_q;
    logic                lock_q;
    logic [IdxWidth-1:0] lidx_q;

    logic                scan_found;
    logic [IdxWidth-1:0] scan_idx;

    // Two passes give the wrap-around scan: first indices at or above the
    // pointer, then the ones below it.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (!scan_found && req_i[i] && (IdxWidth'(i) >= rr_q)) begin
                scan_found = 1'b1;
                scan_idx   = IdxWidth'(i);
            end
        end
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (!scan_found && req_i[i]) begin
                scan_found = 1'b1;
                scan_idx   = IdxWidth'(i);
            end
        end
    end

    assign valid_o = lock_q | scan_found;
    assign idx_o   = lock_q ? lidx_q : scan_idx;

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_gnt
        assign gnt_o[gi] = valid_o && (idx_o == IdxWidth'(gi));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else if (valid_o && ready_i) begin
            lock_q <= 1'b0;
            rr_q   <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
        end else if (valid_o) begin
            lock_q <= 1'b1;
            lidx_q <= idx_o;
        end
    end

endmodule

// File: rtl/mempool_ipu_arbiter.sv
// ---------------------------------------------------------------------------
// mempool_ipu_arbiter
//
// Shares one snitch_ipu between NumCores cores. Requests are round-robin
// arbitrated with a lock; the grant index is prepended to the core's acc id
// and used on the way back to steer the response. Per-core credit counters
// cap the offloads each core may have in flight. Zero-latency datapath.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   core_q*_i / core_qready_o : per-core request channel
//   core_p*_o / core_pready_i : per-core response channel (data/id/error
//                               broadcast, valid one-hot)
//   acc_q*_o / acc_qready_i   : muxed request to the IPU (id widened by tag)
//   acc_p*_i / acc_pready_o   : IPU response channel
// ---------------------------------------------------------------------------
module mempool_ipu_arbiter
    import mempool_ipu_arbiter_pkg::*;
#(
    parameter  int unsigned NumCores       = IpuShareFactor,
    parameter  int unsigned IdWidth        = DefaultIdWidth,
    parameter  int unsigned MaxOutstanding = 2,
    localparam int unsigned IdxWidth       = idx_width(NumCores),
    localparam int unsigned IpuIdWidth     = IdWidth + IdxWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    // core request side
    input  logic [NumCores-1:0][31:0]          core_qaddr_i,
    input  logic [NumCores-1:0][IdWidth-1:0]   core_qid_i,
    input  logic [NumCores-1:0][31:0]          core_qdata_op_i,
    input  logic [NumCores-1:0][31:0]          core_qdata_arga_i,
    input  logic [NumCores-1:0][31:0]          core_qdata_argb_i,
    input  logic [NumCores-1:0][31:0]          core_qdata_argc_i,
    input  logic [NumCores-1:0]                core_qvalid_i,
    output logic [NumCores-1:0]                core_qready_o,
    // core response side
    output logic [NumCores-1:0][31:0]          core_pdata_o,
    output logic [NumCores-1:0][IdWidth-1:0]   core_pid_o,
    output logic [NumCores-1:0]                core_perror_o,
    output logic [NumCores-1:0]                core_pvalid_o,
    input  logic [NumCores-1:0]                core_pready_i,
    // IPU request side
    output logic [31:0]                        acc_qaddr_o,
    output logic [IpuIdWidth-1:0]              acc_qid_o,
    output logic [31:0]                        acc_qdata_op_o,
    output logic [31:0]                        acc_qdata_arga_o,
    output logic [31:0]                        acc_qdata_argb_o,
    output logic [31:0]                        acc_qdata_argc_o,
    output logic                               acc_qvalid_o,
    input  logic                               acc_qready_i,
    // IPU response side
    input  logic [31:0]                        acc_pdata_i,
    input  logic [IpuIdWidth-1:0]              acc_pid_i,
    input  logic                               acc_perror_i,
    input  logic                               acc_pvalid_i,
    output logic                               acc_pready_o
);

    localparam int unsigned        CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);

    logic [NumCores-1:0] eligible;
    logic [NumCores-1:0] gnt;
    logic [NumCores-1:0] req_hs;
    logic [NumCores-1:0] rsp_hs;
    logic [IdxWidth-1:0] gnt_idx;
    logic [IdxWidth-1:0] rsp_idx;
    logic                rsp_in_range;
    logic [CntWidth-1:0] cnt_q [NumCores];

    // Eligibility looks only at the registered count: a credit returned in
    // the same cycle cannot unblock a saturated core until the next cycle.
    for (genvar gi = 0; gi < NumCores; gi++) begin : g_elig
        assign eligible[gi] = core_qvalid_i[gi] && (cnt_q[gi] < CntMax);
    end

    mempool_ipu_arbiter_rr_lock #(
        .NumIn (NumCores)
    ) i_rr_lock (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (eligible),
        .ready_i (acc_qready_i),
        .valid_o (acc_qvalid_o),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    // ---------------- request path ----------------
    assign core_qready_o    = gnt & {NumCores{acc_qready_i}};
    assign req_hs           = core_qready_o;
    assign acc_qaddr_o      = core_qaddr_i[gnt_idx];
    assign acc_qid_o        = {gnt_idx, core_qid_i[gnt_idx]};
    assign acc_qdata_op_o   = core_qdata_op_i[gnt_idx];
    assign acc_qdata_arga_o = core_qdata_arga_i[gnt_idx];
    assign acc_qdata_argb_o = core_qdata_argb_i[gnt_idx];
    assign acc_qdata_argc_o = core_qdata_argc_i[gnt_idx];

    // ---------------- response path ----------------
    assign rsp_idx      = acc_pid_i[IpuIdWidth-1 -: IdxWidth];
    assign rsp_in_range = (32'(rsp_idx) < NumCores);

    for (genvar gi = 0; gi < NumCores; gi++) begin : g_rsp
        assign core_pdata_o[gi]  = acc_pdata_i;
        assign core_pid_o[gi]    = acc_pid_i[IdWidth-1:0];
        assign core_perror_o[gi] = acc_perror_i;
        assign core_pvalid_o[gi] = acc_pvalid_i && (rsp_idx == IdxWidth'(gi));
        assign rsp_hs[gi]        = core_pvalid_o[gi] && core_pready_i[gi];
    end

    // A tag that names no core matches nothing here, so the response is
    // accepted and silently dropped rather than stalling the IPU.
    always_comb begin
        acc_pready_o = 1'b1;
        for (int unsigned i = 0; i < NumCores; i++) begin
            if (rsp_idx == IdxWidth'(i)) begin
                acc_pready_o = core_pready_i[i];
            end
        end
    end

    // ---------------- credit counters ----------------
    for (genvar gi = 0; gi < NumCores; gi++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q[gi] <= '0;
            end else if (req_hs[gi] && !rsp_hs[gi]) begin
                cnt_q[gi] <= cnt_q[gi] + CntWidth'(1);
            end else if (rsp_hs[gi] && !req_hs[gi]) begin
                cnt_q[gi] <= cnt_q[gi] - CntWidth'(1);
            end
        end

`ifndef SYNTHESIS
        a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(rsp_hs[gi] && !req_hs[gi] && (cnt_q[gi] == '0)));
        a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(req_hs[gi] && !rsp_hs[gi] && (cnt_q[gi] == CntMax)));
`endif
    end

`ifndef SYNTHESIS
    a_rsp_tag_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        acc_pvalid_i |-> rsp_in_range);
`endif

endmodule

// File: tb/tb_mempool_ipu_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for mempool_ipu_arbiter (NumCores=4, IdWidth=5, MaxOutstanding=2).
// A behavioural model (scan-from-pointer grant, lock, credit counts, tag
// routing) is checked against the DUT on every falling edge; directed
// scenarios add literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_mempool_ipu_arbiter;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int PW = 7;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0][31:0]   qaddr, qop, qa, qb, qc;
    logic [N-1:0][IW-1:0] qid;
    logic [N-1:0]         qvalid, qready;
    logic [N-1:0][31:0]   pdata_o;
    logic [N-1:0][IW-1:0] pid_o;
    logic [N-1:0]         perror_o, pvalid_o, pready_in;
    logic [31:0]          acc_qaddr, acc_qop, acc_qa, acc_qb, acc_qc;
    logic [PW-1:0]        acc_qid;
    logic                 acc_qvalid, acc_qready;
    logic [31:0]          acc_pdata;
    logic [PW-1:0]        acc_pid;
    logic                 acc_perror, acc_pvalid, acc_pready;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mempool_ipu_arbiter #(
        .NumCores       (N),
        .IdWidth        (IW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .core_qaddr_i      (qaddr),
        .core_qid_i        (qid),
        .core_qdata_op_i   (qop),
        .core_qdata_arga_i (qa),
        .core_qdata_argb_i (qb),
        .core_qdata_argc_i (qc),
        .core_qvalid_i     (qvalid),
        .core_qready_o     (qready),
        .core_pdata_o      (pdata_o),
        .core_pid_o        (pid_o),
        .core_perror_o     (perror_o),
        .core_pvalid_o     (pvalid_o),
        .core_pready_i     (pready_in),
        .acc_qaddr_o       (acc_qaddr),
        .acc_qid_o         (acc_qid),
        .acc_qdata_op_o    (acc_qop),
        .acc_qdata_arga_o  (acc_qa),
        .acc_qdata_argb_o  (acc_qb),
        .acc_qdata_argc_o  (acc_qc),
        .acc_qvalid_o      (acc_qvalid),
        .acc_qready_i      (acc_qready),
        .acc_pdata_i       (acc_pdata),
        .acc_pid_i         (acc_pid),
        .acc_perror_i      (acc_perror),
        .acc_pvalid_i      (acc_pvalid),
        .acc_pready_o      (acc_pready)
    );

    // ---------------- behavioural model ----------------
    int      mdl_rr, mdl_lidx;
    bit      mdl_lock;
    int      mdl_cnt [N];
    bit [N-1:0] mdl_qhs;
    bit      mdl_rhs;

    bit            exp_v;
    int            exp_g;
    int            exp_ridx;
    logic [N-1:0]  exp_qready, exp_pvalid;
    logic [PW-1:0] exp_qid;
    logic          exp_pready;

    always_comb begin
        exp_v      = 1'b0;
        exp_g      = 0;
        exp_qready = '0;
        exp_pvalid = '0;
        if (mdl_lock) begin
            exp_v = 1'b1;
            exp_g = mdl_lidx;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!exp_v && qvalid[(mdl_rr + k) % N] && (mdl_cnt[(mdl_rr + k) % N] < MO)) begin
                    exp_v = 1'b1;
                    exp_g = (mdl_rr + k) % N;
                end
            end
        end
        if (exp_v) exp_qready[exp_g] = acc_qready;
        exp_qid    = {2'(exp_g), qid[exp_g]};
        exp_ridx   = int'(acc_pid[PW-1 -: 2]);
        exp_pvalid[exp_ridx] = acc_pvalid;
        exp_pready = pready_in[exp_ridx];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_rr   <= 0;
            mdl_lidx <= 0;
            mdl_lock <= 1'b0;
            mdl_qhs  <= '0;
            mdl_rhs  <= 1'b0;
            for (int i = 0; i < N; i++) mdl_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mdl_cnt[i] <= mdl_cnt[i]
                    + ((exp_v && acc_qready && exp_g == i) ? 1 : 0)
                    - ((acc_pvalid && exp_ridx == i && pready_in[i]) ? 1 : 0);
                mdl_qhs[i] <= exp_v && acc_qready && (exp_g == i);
            end
            mdl_rhs <= acc_pvalid && exp_pready;
            if (exp_v && acc_qready) begin
                mdl_lock <= 1'b0;
                mdl_rr   <= (exp_g + 1) % N;
            end else if (exp_v) begin
                mdl_lock <= 1'b1;
                mdl_lidx <= exp_g;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("acc_qvalid", 128'(acc_qvalid), 128'(exp_v));
            chk("core_qready", 128'(qready), 128'(exp_qready));
            if (exp_v) begin
                chk("acc_qid", 128'(acc_qid), 128'(exp_qid));
                chk("acc_qaddr", 128'(acc_qaddr), 128'(qaddr[exp_g]));
                chk("acc_qdata", {acc_qop, acc_qa, acc_qb, acc_qc},
                    {qop[exp_g], qa[exp_g], qb[exp_g], qc[exp_g]});
            end
            chk("core_pvalid", 128'(pvalid_o), 128'(exp_pvalid));
            chk("acc_pready", 128'(acc_pready), 128'(exp_pready));
            chk("core_pdata", 128'(pdata_o), {N{acc_pdata}});
            chk("core_pid", 128'(pid_o), 128'({N{acc_pid[IW-1:0]}}));
            chk("core_perror", 128'(perror_o), 128'({N{acc_perror}}));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        qvalid = '0; acc_qready = 1'b0; acc_pvalid = 1'b0; acc_pid = '0;
        acc_pdata = '0; acc_perror = 1'b0; pready_in = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic new_req(input int i);
        qvalid[i] = 1'b1;
        qaddr[i]  = $urandom;
        qop[i]    = $urandom;
        qa[i]     = $urandom;
        qb[i]     = $urandom;
        qc[i]     = $urandom;
        qid[i]    = IW'($urandom_range(0, 31));
    endtask

    task automatic rand_drive();
        int s;
        int j;
        for (int i = 0; i < N; i++) begin
            if (!qvalid[i] || mdl_qhs[i]) begin
                if ($urandom_range(0, 99) < 45) new_req(i);
                else qvalid[i] = 1'b0;
            end
        end
        if (!acc_pvalid || mdl_rhs) begin
            acc_pvalid = 1'b0;
            if ($urandom_range(0, 99) < 60) begin
                s = $urandom_range(0, N - 1);
                for (int t = 0; t < N; t++) begin
                    j = (s + t) % N;
                    if (!acc_pvalid && mdl_cnt[j] > 0) begin
                        acc_pvalid = 1'b1;
                        acc_pid    = {2'(j), IW'($urandom_range(0, 31))};
                        acc_pdata  = $urandom;
                        acc_perror = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
        acc_qready = ($urandom_range(0, 99) < 70);
        pready_in  = N'($urandom_range(0, 15));
    endtask

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        qaddr = '0; qop = '0; qa = '0; qb = '0; qc = '0; qid = '0;
        idle();
        do_reset();
        chk_en = 1'b1;

        // reset state with idle inputs
        @(negedge clk);
        chk("rst_qvalid", 128'(acc_qvalid), 128'(0));
        chk("rst_qready", 128'(qready), 128'(0));
        chk("rst_pvalid", 128'(pvalid_o), 128'(0));
        chk("rst_pready", 128'(acc_pready), 128'(0));
        $display("reset idle check done");

        // single request from core1, id 3
        step();
        qvalid = 4'b0010; qid[1] = 5'd3; acc_qready = 1'b1;
        @(negedge clk);
        chk("t1_qid", 128'(acc_qid), 128'(7'b01_00011));
        chk("t1_qready", 128'(qready), 128'(4'b0010));
        step();
        qvalid = '0; acc_qready = 1'b0;
        chk("t1_cnt1", 128'(mdl_cnt[1]), 128'(1));
        acc_pvalid = 1'b1; acc_pid = 7'b01_00011; pready_in = 4'b0010;
        @(negedge clk);
        chk("t1_pvalid", 128'(pvalid_o), 128'(4'b0010));
        step();
        idle();
        $display("core1 single request done");

        // all four cores busy, IPU always ready: grants rotate 0,1,2,3
        do_reset();
        qvalid = 4'hF; acc_qready = 1'b1; pready_in = 4'hF;
        for (int i = 0; i < N; i++) qid[i] = IW'(i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_grant", 128'(acc_qid[PW-1 -: 2]), 128'(k % N));
            step();
            acc_pvalid = 1'b1;
            acc_pid    = {2'(k % N), 5'(k % N)};
        end
        idle();
        step();
        $display("round-robin rotation done");

        // core2 stalled by IPU; core0 arrives during the stall
        do_reset();
        qvalid = 4'b0100; qaddr[2] = 32'hC0DE_0002; qaddr[0] = 32'h0000_0A00;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) qvalid[0] = 1'b1;
            @(negedge clk);
            chk("t3_idx", 128'(acc_qid[PW-1 -: 2]), 128'(2));
            chk("t3_addr", 128'(acc_qaddr), 128'(32'hC0DE_0002));
            step();
        end
        acc_qready = 1'b1;
        @(negedge clk);
        chk("t3_hs_ready", 128'(qready), 128'(4'b0100));
        step();
        qvalid[2] = 1'b0;
        @(negedge clk);
        chk("t3_next", 128'(qready), 128'(4'b0001));
        step();
        idle();
        $display("lock stability done");

        // credit limit on core0
        do_reset();
        qvalid = 4'b0001; acc_qready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t4_grant", 128'(qready), 128'(4'b0001));
            step();
        end
        @(negedge clk);
        chk("t4_blocked", 128'(qready), 128'(0));
        chk("t4_noqvalid", 128'(acc_qvalid), 128'(0));
        step();
        acc_pvalid = 1'b1; acc_pid = 7'b00_00001; pready_in = 4'b0001;
        @(negedge clk);
        chk("t4_pvalid", 128'(pvalid_o), 128'(4'b0001));
        chk("t4_pid", 128'(pid_o[0]), 128'(1));
        chk("t4_same_cycle", 128'(qready), 128'(0));
        step();
        acc_pvalid = 1'b0;
        @(negedge clk);
        chk("t4_regrant", 128'(qready), 128'(4'b0001));
        step();
        idle();
        $display("credit limit done");

        // response to core3 held off by its ready
        do_reset();
        qvalid = 4'b1000; acc_qready = 1'b1;
        @(negedge clk);
        chk("t5_req", 128'(qready), 128'(4'b1000));
        step();
        qvalid = '0; acc_qready = 1'b0;
        acc_pvalid = 1'b1; acc_pid = 7'b11_10000; pready_in = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t5_stall_pready", 128'(acc_pready), 128'(0));
            chk("t5_stall_pvalid", 128'(pvalid_o), 128'(4'b1000));
            step();
            chk("t5_cnt_held", 128'(mdl_cnt[3]), 128'(1));
        end
        pready_in = 4'b1111;
        @(negedge clk);
        chk("t5_pready", 128'(acc_pready), 128'(1));
        step();
        chk("t5_cnt_dec", 128'(mdl_cnt[3]), 128'(0));
        idle();
        $display("response stall done");

        // asynchronous reset while locked with core0 saturated
        do_reset();
        qvalid = 4'b0001; acc_qready = 1'b1;
        step();
        step();
        qvalid = 4'b0011; acc_qready = 1'b0;
        @(negedge clk);
        chk("t6_pre_idx", 128'(acc_qid[PW-1 -: 2]), 128'(1));
        step();
        chk("t6_locked", 128'(mdl_lock), 128'(1));
        chk("t6_cnt0", 128'(mdl_cnt[0]), 128'(2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_idx", 128'(acc_qid[PW-1 -: 2]), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        acc_qready = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", 128'(qready), 128'(4'b0001));
        step();
        idle();
        $display("reset mid-transaction done");

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            step();
        end
        idle();
        step();
        $display("random traffic done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mempool_ipu_arbiter.md
Name: mempool_ipu_arbiter

Overview:
- Shares one snitch_ipu accelerator instance between NumCores Snitch cores in a tile.
- Requests use round-robin arbitration. The requester index is appended above the core's acc id. Responses are routed back by that index.
- Per-core outstanding-credit counters bound the in-flight offloads from each core.
- Sits between the per-core offload spill registers and the shared IPU. Datapath is purely combinational, latency 0; cuts are provided by the external spill registers.

Parameters:
- NumCores, 4, number of requesting cores; must be ≥ 1.
- IdWidth, 5, width of each core's acc id.
- MaxOutstanding, 2, maximum in-flight offloads per core; must be ≥ 1.
- IdxWidth, (NumCores > 1) ? $clog2(NumCores) : 1, derived requester-tag width.
- IpuIdWidth, IdWidth+IdxWidth, derived; the IPU must be built with IdWidth = IpuIdWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_qaddr_i  in  NumCores×32  per-core request addr
- core_qid_i  in  NumCores×IdWidth  per-core request id
- core_qdata_op_i  in  NumCores×32  per-core opcode
- core_qdata_arga_i / _argb_i / _argc_i  in  NumCores×32 each  operands
- core_qvalid_i  in  NumCores  request valid
- core_qready_o  out  NumCores  request ready
- core_pdata_o  out  NumCores×32  response data, broadcast
- core_pid_o  out  NumCores×IdWidth  response id with tag stripped, broadcast
- core_perror_o  out  NumCores  response error, broadcast
- core_pvalid_o  out  NumCores  response valid, one-hot or zero
- core_pready_i  in  NumCores  response ready
- acc_qaddr_o, acc_qdata_op_o, acc_qdata_arga_o/_argb_o/_argc_o  out  32 each  muxed request
- acc_qid_o  out  IpuIdWidth  {grant index, core id}
- acc_qvalid_o  out  1
- acc_qready_i  in  1
- acc_pdata_i  in  32
- acc_pid_i  in  IpuIdWidth
- acc_perror_i  in  1
- acc_pvalid_i  in  1
- acc_pready_o  out  1

Behaviour:
- Eligibility: core i is eligible when core_qvalid_i[i] && cnt_q[i] < MaxOutstanding.
- Arbitration:
  - Grant g is the first eligible index scanning upward from rr_q, wrapping past NumCores-1 to 0.
  - acc_qvalid_o = any eligible (or lock_q, see Lock).
  - core_qready_o[g] = acc_qready_i. All other core_qready_o bits are 0.
- Lock:
  - If acc_qvalid_o && !acc_qready_i, set lock_q=1 and lidx_q=g.
  - While locked, grant is forced to lidx_q regardless of rr_q and eligibility, so valid and data stay stable until handshake.
  - lock_q clears on handshake.
- Pointer: on request handshake, rr_q <= (g == NumCores-1) ? 0 : g+1. Otherwise rr_q holds.
- Response routing:
  - idx = acc_pid_i[IpuIdWidth-1 -: IdxWidth].
  - core_pvalid_o[idx] = acc_pvalid_i.
  - acc_pready_o = core_pready_i[idx].
  - core_pid_o = acc_pid_i[IdWidth-1:0].
- Out-of-range tag (idx ≥ NumCores): acc_pready_o=1, response is dropped, and a simulation-only assertion fires.
- Counters, width $clog2(MaxOutstanding+1):
  - Increment on request handshake of core i; decrement on response handshake to core i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 and increment at MaxOutstanding are illegal; guarded by assertions.
- Same-cycle credit return does not make a core at MaxOutstanding eligible that cycle. Eligibility uses cnt_q only.
- Reset (async, rst_ni low):
  - State: rr_q=0, lock_q=0, lidx_q=0, all cnt_q=0.
  - With idle inputs, all valid/ready outputs read 0. Data outputs follow the core-0 / IPU inputs combinationally.
- Reset mid-transaction drops all in-flight state. The IPU and spill registers share the same reset.
- NumCores=1: the tag bit is constant 0 and the arbiter degenerates to pass-through with a credit limit.

Decomposition:
- mempool_pkg gains:
  - IpuShareFactor (= NumCores default).
  - acc_ipu_req_t / acc_ipu_resp_t carrying the widened id.
- Natural sub-module: mempool_rr_lock_arbiter.
  - Parameter: NumIn.
  - Ports: req_i, lock handling, rr pointer, gnt_o one-hot, idx_o, valid_o, ready_i.
  - Also reusable for the TCDM side.
- Counters and response demux stay in the top.

Test Plan (NumCores=4, IdWidth=5, MaxOutstanding=2):
- Reset, then core1 requests id=3 with acc_qready_i=1 → acc_qid_o=7'b01_00011 same cycle; core_qready_o=4'b0010; cnt[1]=1 next cycle.
- Cores 0,1,2,3 hold valid continuously with IPU always ready → grants cycle 0,1,2,3,0,… in successive cycles, returning responses to keep credits.
- Core2 valid with acc_qready_i=0 for 3 cycles, core0 raises valid in cycle 2 → grant and data stay on core2 until handshake, then core3/core0 per rr order.
- Core0 issues 2 requests with no responses → third request is blocked (core_qready_o[0]=0); a response with pid=7'b00_00001 and core_pready_i[0]=1 → core_pvalid_o=4'b0001, core_pid_o=1, next cycle core0 is granted.
- Response pid=7'b11_10000 with core_pready_i[3]=0 for 2 cycles → acc_pready_o=0 for those cycles, other cores' pvalid stay 0; cnt[3] decrements only on the ready cycle.
- Assert rst_ni low while lock_q=1 and cnt=2 → all state cleared asynchronously; after release the first grant goes to the lowest eligible index from 0.
